// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail pointer control: allocation to rename, retirement on commit,
// tail rollback on squash followed by a one-cycle recovery bubble.
module rob_ptr_ctrl #(
  parameter int unsigned SIZE         = 128,
  parameter int unsigned RENAME_WIDTH = 4,
  parameter int unsigned COMMIT_WIDTH = 4,
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int unsigned PTR_W = IDX_W + 1,
  localparam int unsigned CNT_W = $clog2(SIZE + 1),
  localparam int unsigned CMT_W = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [RENAME_WIDTH-1:0]              i_alloc_req,
  output logic                                 o_alloc_ready,
  output logic [RENAME_WIDTH-1:0][PTR_W-1:0]   o_alloc_idx,
  input  logic [CMT_W-1:0]                     i_commit_num,
  input  logic                                 i_squash,
  input  logic [PTR_W-1:0]                     i_squash_idx,
  output logic [PTR_W-1:0]                     o_head,
  output logic [PTR_W-1:0]                     o_tail,
  output logic [CNT_W-1:0]                     o_count,
  output logic                                 o_empty,
  output logic                                 o_full,
  output logic                                 o_recovering
);

  localparam int unsigned MAX_W = (RENAME_WIDTH > COMMIT_WIDTH) ? RENAME_WIDTH : COMMIT_WIDTH;
  localparam int unsigned ADD_W = $clog2(MAX_W + 1);
  localparam int unsigned POP_W = $clog2(RENAME_WIDTH + 1);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] head, head_next;
  logic [PTR_W-1:0] tail, tail_next;
  logic [CNT_W-1:0] count;
  logic [POP_W-1:0] pop;
  logic             alloc_fire;

  // Pointer layout is {flipped, idx}; idx wraps at SIZE, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [ADD_W-1:0] n);
    logic [PTR_W-1:0] sum;
    sum = {1'b0, ptr[IDX_W-1:0]} + PTR_W'(n);
    if (sum >= PTR_W'(SIZE))
      ptr_add = {~ptr[IDX_W], IDX_W'(sum - PTR_W'(SIZE))};
    else
      ptr_add = {ptr[IDX_W], sum[IDX_W-1:0]};
  endfunction

  // Ring distance from one pointer forward to another.
  function automatic logic [CNT_W-1:0] ptr_dist(input logic [PTR_W-1:0] from,
                                                input logic [PTR_W-1:0] to);
    if (from[IDX_W] == to[IDX_W])
      ptr_dist = CNT_W'(to[IDX_W-1:0]) - CNT_W'(from[IDX_W-1:0]);
    else
      ptr_dist = CNT_W'(SIZE) - CNT_W'(from[IDX_W-1:0]) + CNT_W'(to[IDX_W-1:0]);
  endfunction

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++)
      pop = pop + POP_W'(i_alloc_req[i]);
  end

  always_comb begin
    for (int unsigned i = 0; i < RENAME_WIDTH; i++)
      o_alloc_idx[i] = ptr_add(tail, ADD_W'(i));
  end

  assign count         = ptr_dist(head, tail);
  assign o_alloc_ready = (state == IDLE) && !i_squash &&
                         ((CNT_W'(SIZE) - count) >= CNT_W'(RENAME_WIDTH));
  assign alloc_fire    = o_alloc_ready && (|i_alloc_req);

  // Next-state: commit always advances head; squash overrides allocation.
  always_comb begin
    state_next = state;
    head_next  = ptr_add(head, ADD_W'(i_commit_num));
    tail_next  = tail;
    if (i_squash) begin
      tail_next  = i_squash_idx;
      state_next = RECOVER;
    end else if (state == RECOVER) begin
      state_next = IDLE;
    end else if (alloc_fire) begin
      tail_next = ptr_add(tail, ADD_W'(pop));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

  assign o_head       = head;
  assign o_tail       = tail;
  assign o_count      = count;
  assign o_empty      = (count == '0);
  assign o_full       = (count == CNT_W'(SIZE));
  assign o_recovering = (state == RECOVER);

  a_alloc_contiguous: assert property (@(posedge clk) disable iff (!rst)
    alloc_fire |-> ((i_alloc_req & (i_alloc_req + RENAME_WIDTH'(1))) == '0));

  a_commit_le_count: assert property (@(posedge clk) disable iff (!rst)
    CNT_W'(i_commit_num) <= count);

  a_squash_in_range: assert property (@(posedge clk) disable iff (!rst)
    i_squash |-> (ptr_dist(head_next, i_squash_idx) <= ptr_dist(head_next, tail)));

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed bench for rob_ptr_ctrl: fill/full, wrap, squash/recover,
// commit+squash to empty, and asynchronous reset during recovery.
module tb_rob_ptr_ctrl;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       alloc_req = '0;
  logic             alloc_ready;
  logic [3:0][7:0]  alloc_idx;
  logic [2:0]       commit_num = '0;
  logic             squash = 1'b0;
  logic [7:0]       squash_idx = '0;
  logic [7:0]       head, tail, count;
  logic             empty, full, recovering;

  int n_checks = 0;
  int n_errors = 0;

  rob_ptr_ctrl #(.SIZE(128), .RENAME_WIDTH(4), .COMMIT_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_alloc_req  (alloc_req),
    .o_alloc_ready(alloc_ready),
    .o_alloc_idx  (alloc_idx),
    .i_commit_num (commit_num),
    .i_squash     (squash),
    .i_squash_idx (squash_idx),
    .o_head       (head),
    .o_tail       (tail),
    .o_count      (count),
    .o_empty      (empty),
    .o_full       (full),
    .o_recovering (recovering)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [3:0] m);
    alloc_req = m;
    tick();
    alloc_req = '0;
  endtask

  task automatic commit(input logic [2:0] n);
    commit_num = n;
    tick();
    commit_num = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // Reset values while rst is held low
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_recov", 32'(recovering), 32'd0);
    check("rst_ready", 32'(alloc_ready), 32'd1);
    check("rst_head",  32'(head), 32'd0);
    check("rst_tail",  32'(tail), 32'd0);
    #2;
    rst = 1'b1;

    // First 4-wide allocation
    alloc_req = 4'b1111;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("a1_idx%0d", i), 32'(alloc_idx[i]), 32'(i));
    tick();
    alloc_req = '0;
    check("a1_tail",  32'(tail), 32'd4);
    check("a1_count", 32'(count), 32'd4);
    check("a1_empty", 32'(empty), 32'd0);

    // Fill to 31 groups, then the 32nd makes it full
    for (int g = 0; g < 30; g++) alloc(4'b1111);
    check("g31_count", 32'(count), 32'd124);
    check("g31_ready", 32'(alloc_ready), 32'd1);
    check("g31_full",  32'(full), 32'd0);
    alloc(4'b1111);
    check("g32_count", 32'(count), 32'd128);
    check("g32_full",  32'(full), 32'd1);
    check("g32_ready", 32'(alloc_ready), 32'd0);
    check("g32_tail",  32'(tail), 32'h80);
    check("g32_head",  32'(head), 32'h00);
    alloc(4'b1111);
    check("full_noalloc_tail", 32'(tail), 32'h80);

    // Commit 4 from full, then allocate across the wrap
    commit(3'd4);
    check("c4_head",  32'(head), 32'h04);
    check("c4_count", 32'(count), 32'd124);
    check("c4_ready", 32'(alloc_ready), 32'd1);
    alloc_req = 4'b1111;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("wrap_idx%0d", i), 32'(alloc_idx[i]), 32'h80 + 32'(i));
    tick();
    alloc_req = '0;
    check("wrap_tail",  32'(tail), 32'h84);
    check("wrap_count", 32'(count), 32'd128);

    // Squash with a concurrent request; request must be ignored
    do_reset();
    for (int g = 0; g < 5; g++) alloc(4'b1111);
    check("sq_pre_tail", 32'(tail), 32'd20);
    squash = 1'b1;
    squash_idx = 8'd12;
    alloc_req = 4'b0011;
    #1;
    check("sq_ready_lo", 32'(alloc_ready), 32'd0);
    tick();
    squash = 1'b0;
    check("sq_tail",     32'(tail), 32'd12);
    check("sq_recov",    32'(recovering), 32'd1);
    check("sq_rec_rdy",  32'(alloc_ready), 32'd0);
    tick();
    alloc_req = '0;
    check("sq_post_tail",  32'(tail), 32'd12);
    check("sq_post_recov", 32'(recovering), 32'd0);
    check("sq_post_ready", 32'(alloc_ready), 32'd1);
    check("sq_post_count", 32'(count), 32'd12);

    // Simultaneous commit and squash to the new head empties the ROB
    do_reset();
    for (int g = 0; g < 3; g++) alloc(4'b1111);
    alloc(4'b0011);
    commit(3'd4);
    commit(3'd4);
    commit(3'd2);
    check("cs_pre_head",  32'(head), 32'd10);
    check("cs_pre_count", 32'(count), 32'd4);
    commit_num = 3'd2;
    squash = 1'b1;
    squash_idx = 8'd12;
    tick();
    commit_num = '0;
    squash = 1'b0;
    check("cs_head",  32'(head), 32'd12);
    check("cs_tail",  32'(tail), 32'd12);
    check("cs_empty", 32'(empty), 32'd1);
    check("cs_count", 32'(count), 32'd0);
    check("cs_recov", 32'(recovering), 32'd1);
    tick();
    check("cs_recov_end", 32'(recovering), 32'd0);

    // Back-to-back squash in RECOVER, then async reset mid-RECOVER
    do_reset();
    for (int g = 0; g < 13; g++) alloc(4'b1111);
    squash = 1'b1;
    squash_idx = 8'd51;
    tick();
    check("bb_tail1",  32'(tail), 32'd51);
    check("bb_recov1", 32'(recovering), 32'd1);
    squash_idx = 8'd50;
    tick();
    squash = 1'b0;
    check("bb_tail2",  32'(tail), 32'd50);
    check("bb_recov2", 32'(recovering), 32'd1);
    check("bb_count",  32'(count), 32'd50);
    #1;
    rst = 1'b0;
    #1;
    check("ar_head",  32'(head), 32'd0);
    check("ar_tail",  32'(tail), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_recov", 32'(recovering), 32'd0);
    check("ar_empty", 32'(empty), 32'd1);
    #1;
    rst = 1'b1;
    tick();
    check("ar_post_recov", 32'(recovering), 32'd0);
    check("ar_post_ready", 32'(alloc_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_ptr_ctrl.md
Name: rob_ptr_ctrl

Overview:
- Manages the ROB's allocation and retirement pointers: hands out robIdx_t values (idx plus flipped wrap bit) to the rename stage and advances the head on commit.
- On branch or exception squash it rolls the tail back, then inserts a one-cycle recovery bubble before allocation resumes.
- Sits between rename/dispatch and the ROB storage; owns no entry payload, only pointer state and flow control.

Parameters:
SIZE, 128, ROB entry count (`ROB_SIZE); any value >= RENAME_WIDTH; power of two not required
RENAME_WIDTH, 4, max entries allocated per cycle
COMMIT_WIDTH, 4, max entries retired per cycle

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
i_alloc_req  in  RENAME_WIDTH  allocation request mask; bits contiguous from bit 0; popcount = entries wanted
o_alloc_ready  out  1  allocation accepted this cycle if high
o_alloc_idx  out  RENAME_WIDTH x robIdx_t  index for lane i = tail + i, with wrap
i_commit_num  in  $clog2(COMMIT_WIDTH+1)  entries retired this cycle
i_squash  in  1  squash request
i_squash_idx  in  robIdx_t  oldest squashed entry; becomes new tail
o_head  out  robIdx_t  oldest live entry
o_tail  out  robIdx_t  next entry to allocate
o_count  out  $clog2(SIZE+1)  live entries
o_empty  out  1  count == 0
o_full  out  1  count == SIZE
o_recovering  out  1  high during the RECOVER state

Behaviour:
Reset (async, rst low):
- head = tail = {flipped 0, idx 0}; state IDLE.
- Outputs: o_count 0, o_empty 1, o_full 0, o_recovering 0, o_alloc_ready 1.
- Asserting rst mid-operation discards all pointers and state immediately.

Pointer arithmetic (ptr + n, n <= max(RENAME_WIDTH, COMMIT_WIDTH)):
- If idx + n >= SIZE: idx' = idx + n - SIZE and flipped toggles.
- Otherwise idx' = idx + n, flipped unchanged.
- Compute in idx width + 1 bit.

Count:
- flipped equal: tail.idx - head.idx.
- flipped differ: SIZE - head.idx + tail.idx.
- Combinational from registered pointers.

o_alloc_ready (combinational):
- High when state == IDLE, i_squash == 0, and (SIZE - count) >= RENAME_WIDTH.
- Depends only on state, i_squash and registered pointers, never on i_alloc_req.

Allocation:
- Fires when o_alloc_ready && |i_alloc_req.
- tail <= tail + popcount(i_alloc_req) at the next edge.
- o_alloc_idx is valid whenever ready is high; unrequested lanes are don't-care.
- Non-contiguous masks are illegal (assertion).

Commit:
- head <= head + i_commit_num each cycle, in any state, including squash and recover cycles.
- i_commit_num > count is illegal (assertion).

State machine (IDLE, RECOVER):
- IDLE --i_squash--> RECOVER. On that edge tail <= i_squash_idx; allocation is blocked that cycle.
- RECOVER lasts exactly 1 cycle: ready = 0, o_recovering = 1. Then returns to IDLE.
- i_squash while in RECOVER: tail <= i_squash_idx and the state stays RECOVER for one more cycle.

Simultaneous commit and squash:
- Both apply.
- i_squash_idx must lie within [head + i_commit_num, tail] in ring order (assertion).
- If it equals the new head, the ROB becomes empty.

Full and empty boundaries:
- count == SIZE: ready 0, o_full 1.
- head == tail with equal flipped: empty.
- head == tail with differing flipped: full.

Test Plan:
- Reset, then i_alloc_req=4'b1111 for one cycle -> o_alloc_idx = {0,1,2,3} flipped 0; next cycle o_tail=4, o_count=4, o_empty=0.
- 32 consecutive 4-wide allocations, no commit -> after 31 groups o_count=124 and ready=1; after the 32nd, o_count=128, o_full=1, o_alloc_ready=0, o_tail={1,0}.
- From full, i_commit_num=4 -> o_head={0,4}, o_count=124, ready=1; next alloc returns idx {0,1,2,3} flipped 1.
- Tail={0,20}, head={0,0}: i_squash with i_squash_idx={0,12} plus i_alloc_req=4'b0011 -> alloc ignored; o_tail={0,12}; o_recovering=1 for exactly 1 cycle; ready returns the following cycle.
- Head={0,10}, tail={0,14}: i_commit_num=2 and i_squash_idx={0,12} in the same cycle -> o_head={0,12}, o_tail={0,12}, o_empty=1, o_count=0.
- Assert rst low mid-RECOVER with count=50 -> o_head=o_tail={0,0}, o_count=0, o_recovering=0 immediately, without waiting for a clock edge.
